// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
//
// Physical-register free list for the rename stage. It keeps one bit per
// physical register (1 = free). A two-sided priority encoder offers two
// registers each cycle: the lowest-index free register on slot 0 and the
// highest-index free register on slot 1. Commit frees and flush masks
// return registers to the list. Rename allocations take registers out.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   alloc_req    [1:0] bit k = rename slot k wants a register
//   alloc_ok     every requested slot can be served (forced low on flush)
//   alloc_preg0  slot-0 offer: lowest-index free register (0 when empty)
//   alloc_preg1  slot-1 offer: highest-index free register (0 when empty)
//   free_valid   [1:0] bit k qualifies free_preg k
//   free_preg0/1 registers returned at commit
//   flush        misprediction recovery; ORs flush_mask into the list
//   flush_mask   registers returned on flush (bit 0 is never returned)
//   free_count   popcount of the registered free bitmap
//   double_free  sticky error: a free targeted an already-free register
// ---------------------------------------------------------------------------

// Two-sided priority encoder. It reports the lowest and highest set bit.
module priority_encoder #(
    parameter int WIDTH    = 8,
    parameter int TWO_SIDE = 1
) (
    input  logic [WIDTH-1:0]         in_vec,
    output logic [$clog2(WIDTH)-1:0] out_lsb,
    output logic [$clog2(WIDTH)-1:0] out_msb,
    output logic                     valid
);
    localparam int IDX_W = $clog2(WIDTH);

    // Lowest set bit: scan downward so that the last hit is the lowest index.
    always_comb begin
        out_lsb = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            out_lsb = in_vec[i] ? IDX_W'(i) : out_lsb;
        end
    end

    // Highest set bit: scan upward so that the last hit is the highest index.
    always_comb begin
        out_msb = '0;
        if (TWO_SIDE != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                out_msb = in_vec[i] ? IDX_W'(i) : out_msb;
            end
        end else begin
            out_msb = '0;
        end
    end

    assign valid = |in_vec;
endmodule

module phys_reg_free_list #(
    parameter int PREGS     = 64,
    parameter int ARCH_REGS = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 alloc_req,
    output logic                       alloc_ok,
    output logic [$clog2(PREGS)-1:0]   alloc_preg0,
    output logic [$clog2(PREGS)-1:0]   alloc_preg1,
    input  logic [1:0]                 free_valid,
    input  logic [$clog2(PREGS)-1:0]   free_preg0,
    input  logic [$clog2(PREGS)-1:0]   free_preg1,
    input  logic                       flush,
    input  logic [PREGS-1:0]           flush_mask,
    output logic [$clog2(PREGS):0]     free_count,
    output logic                       double_free
);
    localparam int IDX_W = $clog2(PREGS);
    localparam int CNT_W = IDX_W + 1;

    // p0..p(ARCH_REGS-1) hold the architectural state at reset.
    localparam logic [PREGS-1:0] RESET_MAP = {PREGS{1'b1}} << ARCH_REGS;
    // p0 backs x0 and must never re-enter the list.
    localparam logic [PREGS-1:0] P0_BIT    = {{(PREGS-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] popcount(input logic [PREGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < PREGS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    logic [PREGS-1:0] free_map_r;
    logic [CNT_W-1:0] free_count_r;
    logic             double_free_r;

    logic [IDX_W-1:0] enc_lsb_s;
    logic [IDX_W-1:0] enc_msb_s;
    logic             enc_valid_s;

    logic             alloc_ok_s;
    logic [PREGS-1:0] alloc_clear_s;
    logic [PREGS-1:0] free_set_s;
    logic [PREGS-1:0] flush_set_s;
    logic [PREGS-1:0] next_map_s;
    logic             double_hit_s;
    logic [IDX_W-1:0] free_preg_s [2];

    priority_encoder #(
        .WIDTH    (PREGS),
        .TWO_SIDE (1)
    ) u_enc (
        .in_vec  (free_map_r),
        .out_lsb (enc_lsb_s),
        .out_msb (enc_msb_s),
        .valid   (enc_valid_s)
    );

    // The offers come only from the registered map. Frees in the same
    // cycle cannot be seen here.
    assign alloc_preg0 = enc_valid_s ? enc_lsb_s : '0;
    assign alloc_preg1 = enc_valid_s ? enc_msb_s : '0;

    assign free_preg_s[0] = free_preg0;
    assign free_preg_s[1] = free_preg1;

    // Grant decision. A dual request needs two distinct free entries.
    always_comb begin
        alloc_ok_s = 1'b0;
        if (flush) begin
            alloc_ok_s = 1'b0;
        end else begin
            case (alloc_req)
                2'b00:        alloc_ok_s = 1'b1;
                2'b01, 2'b10: alloc_ok_s = (free_count_r >= CNT_W'(1));
                2'b11:        alloc_ok_s = (free_count_r >= CNT_W'(2));
                default:      alloc_ok_s = 1'b0;
            endcase
        end
    end

    // Bits taken by rename. Allocation is all-or-nothing on alloc_ok.
    always_comb begin
        alloc_clear_s = '0;
        if (alloc_ok_s) begin
            if (alloc_req[0]) begin
                alloc_clear_s[enc_lsb_s] = 1'b1;
            end else begin
                alloc_clear_s = alloc_clear_s;
            end
            if (alloc_req[1]) begin
                alloc_clear_s[enc_msb_s] = 1'b1;
            end else begin
                alloc_clear_s = alloc_clear_s;
            end
        end else begin
            alloc_clear_s = '0;
        end
    end

    // Commit frees. p0 is ignored. A target that is already free in the
    // registered map flags an error. If both slots name the same register,
    // the register is set once and no error is raised for that alone.
    always_comb begin
        free_set_s   = '0;
        double_hit_s = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (free_valid[k] && (free_preg_s[k] != '0)) begin
                free_set_s[free_preg_s[k]] = 1'b1;
                if (free_map_r[free_preg_s[k]]) begin
                    double_hit_s = 1'b1;
                end else begin
                    double_hit_s = double_hit_s;
                end
            end else begin
                free_set_s = free_set_s;
            end
        end
    end

    // Flush return and next-map composition. Clears apply first and sets
    // apply after them.
    always_comb begin
        flush_set_s = '0;
        if (flush) begin
            flush_set_s = flush_mask & ~P0_BIT;
        end else begin
            flush_set_s = '0;
        end
        next_map_s = (free_map_r & ~alloc_clear_s) | free_set_s | flush_set_s;
    end

    // State register. The count is computed from the next map so that it
    // always equals the popcount of free_map_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_map_r    <= RESET_MAP;
            free_count_r  <= CNT_W'(PREGS - ARCH_REGS);
            double_free_r <= 1'b0;
        end else begin
            free_map_r    <= next_map_s;
            free_count_r  <= popcount(next_map_s);
            double_free_r <= double_free_r | double_hit_s;
        end
    end

    assign alloc_ok    = alloc_ok_s;
    assign free_count  = free_count_r;
    assign double_free = double_free_r;
endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
    logic        clk;
    logic        rst_n;
    logic [1:0]  alloc_req;
    logic        alloc_ok;
    logic [5:0]  alloc_preg0;
    logic [5:0]  alloc_preg1;
    logic [1:0]  free_valid;
    logic [5:0]  free_preg0;
    logic [5:0]  free_preg1;
    logic        flush;
    logic [63:0] flush_mask;
    logic [6:0]  free_count;
    logic        double_free;

    phys_reg_free_list #(.PREGS(64), .ARCH_REGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_ok    (alloc_ok),
        .alloc_preg0 (alloc_preg0),
        .alloc_preg1 (alloc_preg1),
        .free_valid  (free_valid),
        .free_preg0  (free_preg0),
        .free_preg1  (free_preg1),
        .flush       (flush),
        .flush_mask  (flush_mask),
        .free_count  (free_count),
        .double_free (double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        chk;
        logic [1:0]  req;
        logic [1:0]  fv;
        logic [5:0]  fp0;
        logic [5:0]  fp1;
        logic        flush;
        logic [63:0] mask;
        logic        ok;
        logic [5:0]  p0;
        logic [5:0]  p1;
        logic [6:0]  cnt;
        logic        df;
    } vec_t;

    typedef struct {
        int          idx;
        logic        ok;
        logic [5:0]  p0;
        logic [5:0]  p1;
        logic [6:0]  cnt;
        logic        df;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(input logic rst, input logic chk, input logic [1:0] req,
                                input logic [1:0] fv, input int fp0, input int fp1,
                                input logic fl, input logic [63:0] mask, input logic ok,
                                input int p0, input int p1, input int cnt, input logic df);
        vec_t v;
        v.rst_n = rst;  v.chk = chk;  v.req = req;  v.fv = fv;
        v.fp0 = 6'(fp0); v.fp1 = 6'(fp1); v.flush = fl; v.mask = mask;
        v.ok = ok; v.p0 = 6'(p0); v.p1 = 6'(p1); v.cnt = 7'(cnt); v.df = df;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; alloc_req = 2'b00; free_valid = 2'b00;
        free_preg0 = 6'd0; free_preg1 = 6'd0; flush = 1'b0; flush_mask = 64'd0;

        // Initial reset, unchecked.
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b0, 0, 0, 0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b0, 0, 0, 0, 1'b0));
        // Reset state.
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 32, 63, 32, 1'b0));
        // 16 dual allocations drain the list from both ends.
        for (int n = 0; n < 16; n++) begin
            vecs.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 64'd0,
                              1'b1, 32 + n, 63 - n, 32 - 2 * n, 1'b0));
        end
        // The 17th request is refused and the map stays empty.
        vecs.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 64'd0, 1'b0, 0, 0, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 0, 0, 0, 1'b0));
        // A same-cycle free is not offered. It appears on the next cycle.
        vecs.push_back(mk(1'b1, 1'b1, 2'b01, 2'b01, 40, 0, 1'b0, 64'd0, 1'b0, 0, 0, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 64'd0, 1'b0, 40, 40, 1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 40, 40, 1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 0, 0, 0, 1'b0));
        // Double free of p5 sets a sticky error. A free of p0 is ignored.
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b01, 5, 0, 1'b0, 64'd0, 1'b1, 0, 0, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b01, 5, 0, 1'b0, 64'd0, 1'b1, 5, 5, 1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b01, 0, 0, 1'b0, 64'd0, 1'b1, 5, 5, 1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 5, 5, 1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 5, 5, 1, 1'b1));
        // A flush on an empty map returns the mask except p0.
        vecs.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, 0, 0, 1'b1, 64'hFFFF_0000_0000_0001,
                          1'b0, 0, 0, 0, 1'b1));
        // A flush blocks allocation. A commit free lands in the same cycle.
        vecs.push_back(mk(1'b1, 1'b1, 2'b01, 2'b01, 20, 0, 1'b1, 64'd0, 1'b0, 48, 63, 16, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 20, 63, 17, 1'b1));
        // Ten mixed cycles, unchecked. They are followed by a one-cycle
        // reset with every other input active.
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(1'b1, 1'b0, 2'(i % 4), 2'b11, i + 1, i + 40, 1'b0, 64'd0,
                              1'b0, 0, 0, 0, 1'b0));
        end
        vecs.push_back(mk(1'b0, 1'b0, 2'b11, 2'b11, 3, 4, 1'b1, {64{1'b1}}, 1'b0, 0, 0, 0, 1'b0));
        // The exact reset values return.
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 32, 63, 32, 1'b0));
        // A single request on slot 1 takes the MSB offer.
        vecs.push_back(mk(1'b1, 1'b1, 2'b10, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 32, 63, 32, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 32, 62, 31, 1'b0));
        // Both slots free p7: the bit is set once and no error is raised.
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b11, 7, 7, 1'b0, 64'd0, 1'b1, 32, 62, 31, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 7, 62, 32, 1'b0));
        // Two distinct frees in one cycle.
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b11, 8, 9, 1'b0, 64'd0, 1'b1, 7, 62, 32, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 64'd0, 1'b1, 7, 62, 34, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            rst_n = v.rst_n;  alloc_req = v.req;  free_valid = v.fv;
            free_preg0 = v.fp0; free_preg1 = v.fp1; flush = v.flush; flush_mask = v.mask;
            if (v.chk) begin
                e.idx = i; e.ok = v.ok; e.p0 = v.p0; e.p1 = v.p1; e.cnt = v.cnt; e.df = v.df;
                exp_q.push_back(e);
            end else begin
                e.idx = -1;
            end
            @(negedge clk);
            if (v.chk) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard vec%0d: got empty queue, want one entry", i);
                end else begin
                    e = exp_q.pop_front();
                    check("alloc_ok",    e.idx, longint'(alloc_ok),    longint'(e.ok));
                    check("alloc_preg0", e.idx, longint'(alloc_preg0), longint'(e.p0));
                    check("alloc_preg1", e.idx, longint'(alloc_preg1), longint'(e.p1));
                    check("free_count",  e.idx, longint'(free_count),  longint'(e.cnt));
                    check("double_free", e.idx, longint'(double_free), longint'(e.df));
                end
            end else begin
                e.idx = -1;
            end
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Physical-register free list for the rename stage. It holds a PREGS-bit bitmap of free physical registers and drives that bitmap into an internal `priority_encoder` instance (WIDTH=PREGS, TWO_SIDE=1). Each cycle it offers up to two free registers: the lowest-index one comes from the LSB side and the highest-index one from the MSB side. Commit and flush return registers to the list; rename consumes them.

## Interface
- PREGS, 64, number of physical registers; a multiple of 4 and at least 8
- ARCH_REGS, 32, architectural registers; p0..p(ARCH_REGS-1) start allocated
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- alloc_req  in  2  bit k = rename slot k wants a destination register this cycle
- alloc_ok  out  1  all requested slots can be satisfied
- alloc_preg0  out  $clog2(PREGS)  slot-0 register: lowest-index free entry
- alloc_preg1  out  $clog2(PREGS)  slot-1 register: highest-index free entry
- free_valid  in  2  commit-side frees, bit k qualifies free_preg k
- free_preg0, free_preg1  in  $clog2(PREGS) each  registers being returned
- flush  in  1  misprediction recovery; OR flush_mask into the list
- flush_mask  in  PREGS  registers to return on flush
- free_count  out  $clog2(PREGS)+1  popcount of the free bitmap
- double_free  out  1  sticky error: a free targeted an entry that was already free

## Operation
- State:
  - free_map[PREGS-1:0], bit i = 1 means p(i) is free.
  - double_free flag.
- Reset (rst_n=0 at an edge):
  - free_map bits [ARCH_REGS-1:0] = 0; all other bits = 1.
  - double_free = 0.
  - Outputs after reset: free_count = PREGS-ARCH_REGS; alloc_preg0 = ARCH_REGS; alloc_preg1 = PREGS-1; alloc_ok = 1 for any request.
- Offer, combinational from registered free_map only:
  - alloc_preg0 = encoder out_LSB.
  - alloc_preg1 = encoder out_MSB.
  - Both are 0 when the map is empty.
- alloc_ok rules:
  - 2'b00: alloc_ok = 1.
  - One bit set: alloc_ok = 1 iff free_count ≥ 1.
  - 2'b11: alloc_ok = 1 iff free_count ≥ 2, which guarantees preg0 ≠ preg1.
  - flush=1 forces alloc_ok = 0.
- Allocation is all-or-nothing. When alloc_ok=1 and flush=0, each requested slot clears its offered bit at the edge. Rename stalls while alloc_ok=0, and nothing is cleared.
- Free: for each k with free_valid[k]=1, bit free_preg k is set at the edge.
  - free_preg = 0 is ignored, because p0 backs x0 and is never freed.
  - If the target bit is already 1 in free_map, double_free is set (sticky until reset) and the bit stays 1.
  - free_preg0 == free_preg1 with both valid: the bit is set once and no error is raised, unless the bit was already free.
- Flush: free_map |= flush_mask & ~1 (bit 0 excluded). Commit frees apply in the same cycle as a flush.
- Next-state order within one edge: clear allocated bits, then set free and flush bits. A register freed in cycle N is offerable from cycle N+1 onward, never in cycle N.
- Bitmap update rule: next_map = (free_map & ~alloc_clear) | free_set | flush_set.

## Timing
- Offer latency: 0 cycles from free_map (combinational). Bitmap update takes effect 1 cycle after the request or free.
- Throughput: 2 allocations and 2 frees per cycle with no bubbles.
- free_count and the offers reflect only the registered map, never same-cycle frees.
- Reset beats every other input: alloc, free and flush are all ignored in a reset cycle.
- Reset mid-operation returns the map to the reset pattern on the next edge, whatever the map held before.
- Empty map: alloc_ok = 0 for any nonzero request; the offers read 0 and must be ignored.
- Full map (all bits except p0 set): frees set double_free.

## Test plan
- Reset with PREGS=64, ARCH_REGS=32 -> free_count=32, alloc_preg0=32, alloc_preg1=63, double_free=0.
- alloc_req=2'b11 for 16 consecutive cycles from reset -> cycle n grants 32+n and 63-n; free_count then reads 0; the 17th request sees alloc_ok=0 and the map is unchanged.
- Map empty, free_valid=2'b01 with free_preg0=40 and alloc_req=2'b01 in the same cycle -> alloc_ok=0 that cycle; next cycle alloc_preg0=alloc_preg1=40, free_count=1; alloc_req=2'b11 gives alloc_ok=0 and 2'b01 gives alloc_ok=1.
- Free p5 while p5 is free, and separately free p0 -> the first sets double_free=1 and it stays 1; the second changes nothing.
- flush=1 with flush_mask=64'hFFFF_0000_0000_0001 on an empty map, alloc_req=2'b11 -> alloc_ok=0; next cycle free_count=16, alloc_preg0=48, alloc_preg1=63.
- Drive rst_n=0 for one cycle after 10 mixed alloc/free cycles -> state returns to the exact reset values of scenario 1.
